reflet_uart_boot_loader: RTL and testbench

- Bootloader front-end for the 16-bit controller.
- Deserialises a raw UART byte stream from the rx pin, writes each byte sequentially into instruction RAM starting at a base address, and holds the CPU in reset while loading.
- When the stream goes idle, or the image size limit is reached, it releases the CPU so it starts executing the loaded program.
- Sits between the external rx pin and the controller's memory write port / CPU reset input.

---
 rtl/reflet_uart_boot_loader.sv | 216 +++++++++++++++++++++
 tb/tb_reflet_uart_boot_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_uart_boot_loader.sv
// UART boot loader: deserialises bytes from rx into instruction RAM from load_base,
// holding the CPU in reset until the stream goes idle or the image size limit is hit.
module reflet_uart_boot_loader #(
  parameter int clk_freq     = 1000000,
  parameter int baud_rate    = 9600,
  parameter int addr_width   = 16,
  parameter int load_base    = 0,
  parameter int max_size     = 256,
  parameter int idle_bytes   = 4,
  parameter bit wait_forever = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [addr_width-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_we,
  output logic                  cpu_reset,
  output logic                  loading,
  output logic [addr_width:0]   byte_count,
  output logic                  framing_error
);

  localparam int raw_div        = clk_freq / baud_rate;
  localparam int divisor        = (raw_div < 4) ? 4 : raw_div;
  localparam int timeout_cycles = idle_bytes * 10 * divisor;
  localparam int tw             = $clog2(divisor);
  localparam int iw             = $clog2(timeout_cycles + 1);

  localparam logic [tw-1:0]         half_pt     = tw'(divisor / 2);
  localparam logic [tw-1:0]         bit_last    = tw'(divisor - 1);
  localparam logic [tw-1:0]         tmr_one     = tw'(1);
  localparam logic [iw-1:0]         timeout_cnt = iw'(timeout_cycles);
  localparam logic [iw-1:0]         idle_one    = iw'(1);
  localparam logic [addr_width-1:0] base_addr   = addr_width'(load_base);
  localparam logic [addr_width:0]   max_cnt     = (addr_width + 1)'(max_size);
  localparam logic [addr_width:0]   cnt_one     = (addr_width + 1)'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {WAIT_FIRST, LOADING, BOOT} top_state_e;

  // Receiver state
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [tw-1:0]   rx_timer_q, rx_timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            framing_error_q, framing_error_d;
  logic            start_edge;

  // Loader state
  top_state_e              top_q, top_d;
  logic [iw-1:0]           idle_q, idle_d;
  logic [addr_width-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]              mem_data_q, mem_data_d;
  logic                    mem_we_q, mem_we_d;
  logic [addr_width:0]     byte_count_q, byte_count_d;
  logic                    timeout_hit;

  // rx is asynchronous; only rx_sync_q (and its delayed copy) is ever decoded.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statement can infer a latch.
    rx_state_d      = rx_state_q;
    rx_timer_d      = rx_timer_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    byte_valid_d    = 1'b0;
    framing_error_d = framing_error_q;
    start_edge      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          start_edge = 1'b1;
          rx_state_d = RX_START;
          rx_timer_d = '0;
        end
      end
      RX_START: begin
        if (rx_timer_q == half_pt) begin
          rx_timer_d = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_timer_d = rx_timer_q + tmr_one;
        end
      end
      RX_DATA: begin
        if (rx_timer_q == bit_last) begin
          rx_timer_d = '0;
          shift_d    = {rx_sync_q, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_timer_d = rx_timer_q + tmr_one;
        end
      end
      RX_STOP: begin
        if (rx_timer_q == bit_last) begin
          rx_timer_d = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) byte_valid_d    = 1'b1;
          else           framing_error_d = 1'b1;
        end else begin
          rx_timer_d = rx_timer_q + tmr_one;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q      <= RX_IDLE;
      rx_timer_q      <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      byte_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_state_q      <= rx_state_d;
      rx_timer_q      <= rx_timer_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      byte_valid_q    <= byte_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  always_comb begin
    top_d        = top_q;
    idle_d       = idle_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    byte_count_d = byte_count_q;

    // Idle timer saturates, so a long WAIT_FIRST with wait_forever set cannot wrap.
    if (start_edge) begin
      idle_d = '0;
    end else if (rx_state_q == RX_IDLE && top_q != BOOT && idle_q != timeout_cnt) begin
      idle_d = idle_q + idle_one;
    end
    timeout_hit = (idle_d == timeout_cnt);

    case (top_q)
      WAIT_FIRST: begin
        if (byte_valid_q) begin
          mem_we_d     = 1'b1;
          mem_data_d   = shift_q;
          mem_addr_d   = base_addr + byte_count_q[addr_width-1:0];
          byte_count_d = byte_count_q + cnt_one;
          top_d        = LOADING;
        end else if (!wait_forever && timeout_hit) begin
          top_d = BOOT;
        end
      end
      LOADING: begin
        if (byte_count_q == max_cnt) begin
          top_d = BOOT;
        end else if (byte_valid_q) begin
          mem_we_d     = 1'b1;
          mem_data_d   = shift_q;
          mem_addr_d   = base_addr + byte_count_q[addr_width-1:0];
          byte_count_d = byte_count_q + cnt_one;
        end else if (timeout_hit) begin
          top_d = BOOT;
        end
      end
      BOOT:    top_d = BOOT;
      default: top_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q        <= WAIT_FIRST;
      idle_q       <= '0;
      mem_addr_q   <= base_addr;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      byte_count_q <= '0;
    end else begin
      top_q        <= top_d;
      idle_q       <= idle_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign mem_we        = mem_we_q;
  assign byte_count    = byte_count_q;
  assign framing_error = framing_error_q;
  assign cpu_reset     = (top_q == BOOT);
  assign loading       = (top_q != BOOT);

endmodule

// File: tb/tb_reflet_uart_boot_loader.sv
// Directed bench for reflet_uart_boot_loader: three instances share clk/reset/rx and
// differ in max_size and wait_forever; divisor is 10 so timeout is 400 cycles.
module tb_reflet_uart_boot_loader;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;

  logic [15:0] mem_addr_a, mem_addr_b, mem_addr_c;
  logic [7:0]  mem_data_a, mem_data_b, mem_data_c;
  logic        mem_we_a, mem_we_b, mem_we_c;
  logic        cpu_reset_a, cpu_reset_b, cpu_reset_c;
  logic        loading_a, loading_b, loading_c;
  logic [16:0] byte_count_a, byte_count_b, byte_count_c;
  logic        framing_error_a, framing_error_b, framing_error_c;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int rise_a = -1, rise_b = -1, rise_c = -1;
  logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;
  wr_t wr_a[$], wr_b[$], wr_c[$];

  always #5 clk = ~clk;

  reflet_uart_boot_loader #(.clk_freq(1000000), .baud_rate(100000), .addr_width(16),
    .load_base(0), .max_size(256), .idle_bytes(4), .wait_forever(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rx(rx), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .mem_we(mem_we_a), .cpu_reset(cpu_reset_a), .loading(loading_a),
    .byte_count(byte_count_a), .framing_error(framing_error_a));

  reflet_uart_boot_loader #(.clk_freq(1000000), .baud_rate(100000), .addr_width(16),
    .load_base(0), .max_size(3), .idle_bytes(4), .wait_forever(1'b1)) dut_b (
    .clk(clk), .reset(reset), .rx(rx), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .mem_we(mem_we_b), .cpu_reset(cpu_reset_b), .loading(loading_b),
    .byte_count(byte_count_b), .framing_error(framing_error_b));

  reflet_uart_boot_loader #(.clk_freq(1000000), .baud_rate(100000), .addr_width(16),
    .load_base(0), .max_size(256), .idle_bytes(4), .wait_forever(1'b0)) dut_c (
    .clk(clk), .reset(reset), .rx(rx), .mem_addr(mem_addr_c), .mem_data(mem_data_c),
    .mem_we(mem_we_c), .cpu_reset(cpu_reset_c), .loading(loading_c),
    .byte_count(byte_count_c), .framing_error(framing_error_c));

  // Write and boot monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t w;
    cyc = cyc + 1;
    if (mem_we_a) begin w.addr = mem_addr_a; w.data = mem_data_a; w.cyc = cyc; wr_a.push_back(w); end
    if (mem_we_b) begin w.addr = mem_addr_b; w.data = mem_data_b; w.cyc = cyc; wr_b.push_back(w); end
    if (mem_we_c) begin w.addr = mem_addr_c; w.data = mem_data_c; w.cyc = cyc; wr_c.push_back(w); end
    if (cpu_reset_a && !prev_a) rise_a = cyc;
    if (cpu_reset_b && !prev_b) rise_b = cyc;
    if (cpu_reset_c && !prev_c) rise_c = cyc;
    prev_a = cpu_reset_a;
    prev_b = cpu_reset_b;
    prev_c = cpu_reset_c;
  end

  task automatic assert_reset();
    @(negedge clk);
    #3 reset = 1'b0;
    rx = 1'b1;
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    rel_cyc = cyc;
    wr_a.delete(); wr_b.delete(); wr_c.delete();
    rise_a = -1; rise_b = -1; rise_c = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    assert_reset();
    #1;
    vectors++;
    if (mem_addr_a !== 16'h0 || mem_data_a !== 8'h0 || mem_we_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mem: addr=%h data=%h we=%b expected 0000/00/0", mem_addr_a, mem_data_a, mem_we_a);
    end
    vectors++;
    if (cpu_reset_a !== 1'b0 || loading_a !== 1'b1 || byte_count_a !== 17'd0 || framing_error_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: cpu_reset=%b loading=%b count=%0d ferr=%b expected 0/1/0/0",
               cpu_reset_a, loading_a, byte_count_a, framing_error_a);
    end
    release_reset();
    repeat (5) @(negedge clk);
    vectors++;
    if (cpu_reset_c !== 1'b0 || loading_c !== 1'b1 || byte_count_c !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_release: cpu_reset=%b loading=%b count=%0d expected 0/1/0", cpu_reset_c, loading_c, byte_count_c);
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] img [6];
    img = '{8'h04, 8'h03, 8'h02, 8'h01, 8'hE9, 8'hE8};
    assert_reset();
    release_reset();
    for (int i = 0; i < 6; i++) send_byte(img[i], 1'b1);
    for (int i = 0; i < 600 && rise_a < 0; i++) @(negedge clk);
    vectors++;
    if (wr_a.size() != 6) begin
      miscompares++;
      $display("FAIL basic_nwrites: got %0d expected 6", wr_a.size());
    end
    for (int i = 0; i < 6 && i < wr_a.size(); i++) begin
      vectors++;
      if (wr_a[i].addr !== 16'(i) || wr_a[i].data !== img[i]) begin
        miscompares++;
        $display("FAIL basic_write%0d: got %h@%h expected %h@%h", i, wr_a[i].data, wr_a[i].addr, img[i], 16'(i));
      end
    end
    vectors++;
    if (byte_count_a !== 17'd6) begin
      miscompares++;
      $display("FAIL basic_count: got %0d expected 6", byte_count_a);
    end
    // cpu_reset rises 400 cycles after the stop sample; mem_we is 1 cycle after it.
    vectors++;
    if (rise_a < 0 || wr_a.size() == 0 || rise_a - wr_a[wr_a.size()-1].cyc != 399) begin
      miscompares++;
      $display("FAIL basic_boot_time: rise=%0d last_we=%0d expected delta 399", rise_a,
               (wr_a.size() == 0) ? -1 : wr_a[wr_a.size()-1].cyc);
    end
    vectors++;
    if (cpu_reset_a !== 1'b1 || loading_a !== 1'b0 || mem_addr_a !== 16'h5 || mem_data_a !== 8'hE8) begin
      miscompares++;
      $display("FAIL basic_hold: cpu_reset=%b loading=%b addr=%h data=%h expected 1/0/0005/e8",
               cpu_reset_a, loading_a, mem_addr_a, mem_data_a);
    end
  endtask

  task automatic test_framing();
    assert_reset();
    release_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    vectors++;
    if (framing_error_a !== 1'b1) begin
      miscompares++;
      $display("FAIL framing_flag: got %b expected 1", framing_error_a);
    end
    vectors++;
    if (wr_a.size() != 2 || byte_count_a !== 17'd2) begin
      miscompares++;
      $display("FAIL framing_count: writes=%0d count=%0d expected 2/2", wr_a.size(), byte_count_a);
    end else begin
      vectors++;
      if (wr_a[0].addr !== 16'h0 || wr_a[0].data !== 8'h11 || wr_a[1].addr !== 16'h1 || wr_a[1].data !== 8'h22) begin
        miscompares++;
        $display("FAIL framing_data: got %h@%h %h@%h expected 11@0000 22@0001",
                 wr_a[0].data, wr_a[0].addr, wr_a[1].data, wr_a[1].addr);
      end
    end
  endtask

  task automatic test_glitch();
    assert_reset();
    release_reset();
    repeat (5) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (700) @(negedge clk);
    vectors++;
    if (wr_a.size() != 0 || byte_count_a !== 17'd0 || framing_error_a !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_nowrite: writes=%0d count=%0d ferr=%b expected 0/0/0", wr_a.size(), byte_count_a, framing_error_a);
    end
    vectors++;
    if (cpu_reset_a !== 1'b0 || loading_a !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_wait: cpu_reset=%b loading=%b expected 0/1", cpu_reset_a, loading_a);
    end
  endtask

  task automatic test_max_size();
    logic [7:0] img [5];
    img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    assert_reset();
    release_reset();
    for (int i = 0; i < 5; i++) send_byte(img[i], 1'b1);
    repeat (20) @(negedge clk);
    vectors++;
    if (wr_b.size() != 3 || byte_count_b !== 17'd3) begin
      miscompares++;
      $display("FAIL max_nwrites: writes=%0d count=%0d expected 3/3", wr_b.size(), byte_count_b);
    end
    for (int i = 0; i < 3 && i < wr_b.size(); i++) begin
      vectors++;
      if (wr_b[i].addr !== 16'(i) || wr_b[i].data !== img[i]) begin
        miscompares++;
        $display("FAIL max_write%0d: got %h@%h expected %h@%h", i, wr_b[i].data, wr_b[i].addr, img[i], 16'(i));
      end
    end
    vectors++;
    if (wr_b.size() < 3 || rise_b < 0 || rise_b - wr_b[2].cyc != 1) begin
      miscompares++;
      $display("FAIL max_boot_time: rise=%0d third_we=%0d expected delta 1", rise_b,
               (wr_b.size() < 3) ? -1 : wr_b[2].cyc);
    end
  endtask

  task automatic test_no_wait();
    assert_reset();
    release_reset();
    repeat (450) @(negedge clk);
    vectors++;
    if (rise_c < 0 || rise_c - rel_cyc != 400) begin
      miscompares++;
      $display("FAIL nowait_boot_time: got %0d cycles expected 400", (rise_c < 0) ? -1 : rise_c - rel_cyc);
    end
    vectors++;
    if (byte_count_c !== 17'd0 || wr_c.size() != 0 || cpu_reset_c !== 1'b1) begin
      miscompares++;
      $display("FAIL nowait_state: count=%0d writes=%0d cpu_reset=%b expected 0/0/1", byte_count_c, wr_c.size(), cpu_reset_c);
    end
    vectors++;
    if (cpu_reset_a !== 1'b0) begin
      miscompares++;
      $display("FAIL nowait_forever_inst: cpu_reset=%b expected 0", cpu_reset_a);
    end
  endtask

  task automatic test_reset_mid_load();
    assert_reset();
    release_reset();
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b1);
    vectors++;
    if (byte_count_a !== 17'd2) begin
      miscompares++;
      $display("FAIL midload_pre: count=%0d expected 2", byte_count_a);
    end
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (15) @(negedge clk);
    rx = 1'b0;
    repeat (7) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (byte_count_a !== 17'd0 || mem_addr_a !== 16'h0 || framing_error_a !== 1'b0 || loading_a !== 1'b1) begin
      miscompares++;
      $display("FAIL midload_async: count=%0d addr=%h ferr=%b loading=%b expected 0/0000/0/1",
               byte_count_a, mem_addr_a, framing_error_a, loading_a);
    end
    rx = 1'b1;
    release_reset();
    repeat (5) @(negedge clk);
    send_byte(8'hAA, 1'b1);
    repeat (10) @(negedge clk);
    vectors++;
    if (wr_a.size() != 1 || byte_count_a !== 17'd1 || framing_error_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_reload: writes=%0d count=%0d ferr=%b expected 1/1/0", wr_a.size(), byte_count_a, framing_error_a);
    end else begin
      vectors++;
      if (wr_a[0].addr !== 16'h0 || wr_a[0].data !== 8'hAA) begin
        miscompares++;
        $display("FAIL midload_data: got %h@%h expected aa@0000", wr_a[0].data, wr_a[0].addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_framing();
    test_glitch();
    test_max_size();
    test_no_wait();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
